// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//    Instruction fetch stage. Holds the PC, issues at most one outstanding
//    request to instruction memory and writes the IF/ID pipeline register,
//    which the decode stage consumes every cycle. Each fetched word is
//    pre-decoded into opcode / register / function fields. A redirect
//    (BPUClearCtr) discards in-flight work and restarts fetch at BPUTarget.
//    Cycles without a fetched instruction present an all-zero bubble with
//    if_diffen = 0.
//
// Ports
//    clk, rst            : clock, asynchronous active-high reset
//    BPUClearCtr         : redirect / flush request
//    BPUTarget[31:0]     : redirect PC (low two bits forced to zero)
//    imem_req            : fetch request valid (combinational)
//    imem_addr[31:0]     : fetch address, always the current PC
//    imem_ready          : memory accepts the request this cycle
//    imem_rvalid         : one-cycle response valid
//    imem_rdata[31:0]    : fetched instruction word
//    IDReg_PC/Instr      : PC and word held in the IF/ID register
//    IDReg_op/Regrd/Func3/rs1/rs2/Func7 : predecoded instruction fields
//    if_diffen           : IF/ID register holds a real instruction
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        BPUClearCtr,
   input  logic [31:0] BPUTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IDReg_PC,
   output logic [31:0] IDReg_Instr,
   output logic [6:0]  IDReg_op,
   output logic [4:0]  IDReg_Regrd,
   output logic [2:0]  IDReg_Func3,
   output logic [4:0]  IDReg_rs1,
   output logic [4:0]  IDReg_rs2,
   output logic [6:0]  IDReg_Func7,
   output logic        if_diffen
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // request presented to memory
      S_WAIT = 2'd1,   // request accepted, waiting for its response
      S_DROP = 2'd2    // redirected while waiting; stale response still due
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] target_s;
   logic        load_s;

   // Redirect targets are word aligned.
   assign target_s  = {BPUTarget[31:2], 2'b00};

   // A response is kept only if it answers a live request and no flush
   // arrives on the same edge.
   assign load_s    = (state_q == S_WAIT) && imem_rvalid && !BPUClearCtr;

   // The request is suppressed during a redirect so it can never handshake
   // with the stale PC.
   assign imem_req  = (state_q == S_REQ) && !BPUClearCtr;
   assign imem_addr = pc_q;

   // Fetch FSM, PC and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         IDReg_PC    <= 32'h0000_0000;
         IDReg_Instr <= 32'h0000_0000;
         IDReg_op    <= 7'd0;
         IDReg_Regrd <= 5'd0;
         IDReg_Func3 <= 3'd0;
         IDReg_rs1   <= 5'd0;
         IDReg_rs2   <= 5'd0;
         IDReg_Func7 <= 7'd0;
         if_diffen   <= 1'b0;
      end else begin
         // IF/ID register: load on a kept response, bubble otherwise.
         if (load_s) begin
            IDReg_PC    <= pc_q;
            IDReg_Instr <= imem_rdata;
            IDReg_op    <= imem_rdata[6:0];
            IDReg_Regrd <= imem_rdata[11:7];
            IDReg_Func3 <= imem_rdata[14:12];
            IDReg_rs1   <= imem_rdata[19:15];
            IDReg_rs2   <= imem_rdata[24:20];
            IDReg_Func7 <= imem_rdata[31:25];
            if_diffen   <= 1'b1;
         end else begin
            IDReg_PC    <= 32'h0000_0000;
            IDReg_Instr <= 32'h0000_0000;
            IDReg_op    <= 7'd0;
            IDReg_Regrd <= 5'd0;
            IDReg_Func3 <= 3'd0;
            IDReg_rs1   <= 5'd0;
            IDReg_rs2   <= 5'd0;
            IDReg_Func7 <= 7'd0;
            if_diffen   <= 1'b0;
         end

         case (state_q)
            S_REQ: begin
               // Any rvalid here is a memory protocol error and is ignored.
               if (BPUClearCtr) begin
                  pc_q <= target_s;
               end else if (imem_ready) begin
                  state_q <= S_WAIT;
               end else begin
                  state_q <= S_REQ;
               end
            end
            S_WAIT: begin
               if (imem_rvalid && !BPUClearCtr) begin
                  pc_q    <= pc_q + 32'd4;   // wraps modulo 2^32
                  state_q <= S_REQ;
               end else if (imem_rvalid) begin
                  pc_q    <= target_s;
                  state_q <= S_REQ;
               end else if (BPUClearCtr) begin
                  pc_q    <= target_s;
                  state_q <= S_DROP;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_DROP: begin
               // Further redirects only retarget; the stale response must
               // still be swallowed before a new request may go out.
               if (BPUClearCtr) begin
                  pc_q <= target_s;
               end else begin
                  pc_q <= pc_q;
               end
               if (imem_rvalid) begin
                  state_q <= S_REQ;
               end else begin
                  state_q <= S_DROP;
               end
            end
            default: begin
               state_q <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   logic        clk;
   logic        rst;
   logic        BPUClearCtr;
   logic [31:0] BPUTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] IDReg_PC;
   logic [31:0] IDReg_Instr;
   logic [6:0]  IDReg_op;
   logic [4:0]  IDReg_Regrd;
   logic [2:0]  IDReg_Func3;
   logic [4:0]  IDReg_rs1;
   logic [4:0]  IDReg_rs2;
   logic [6:0]  IDReg_Func7;
   logic        if_diffen;

   int total;
   int bad;

   // Transaction-level model: PC, one outstanding request (with a stale
   // flag) and the expected IF/ID contents.
   logic [31:0] m_pc;
   bit          m_busy;
   bit          m_stale;
   logic [31:0] m_req_pc;
   logic [31:0] e_pc;
   logic [31:0] e_instr;
   bit          e_diffen;

   ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst(rst),
      .BPUClearCtr(BPUClearCtr), .BPUTarget(BPUTarget),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IDReg_PC(IDReg_PC), .IDReg_Instr(IDReg_Instr), .IDReg_op(IDReg_op),
      .IDReg_Regrd(IDReg_Regrd), .IDReg_Func3(IDReg_Func3), .IDReg_rs1(IDReg_rs1),
      .IDReg_rs2(IDReg_rs2), .IDReg_Func7(IDReg_Func7), .if_diffen(if_diffen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 32'h8000_0000;
      m_busy   = 1'b0;
      m_stale  = 1'b0;
      m_req_pc = 32'h0;
      e_pc     = 32'h0;
      e_instr  = 32'h0;
      e_diffen = 1'b0;
   endtask

   // Compare every DUT output against the model.
   task automatic compare_all();
      chk("imem_req",  {31'd0, imem_req}, {31'd0, (!m_busy && !BPUClearCtr)});
      chk("imem_addr", imem_addr, m_pc);
      chk("IDReg_PC",  IDReg_PC, e_pc);
      chk("IDReg_Instr", IDReg_Instr, e_instr);
      chk("IDReg_op",    {25'd0, IDReg_op},    {25'd0, e_instr[6:0]});
      chk("IDReg_Regrd", {27'd0, IDReg_Regrd}, {27'd0, e_instr[11:7]});
      chk("IDReg_Func3", {29'd0, IDReg_Func3}, {29'd0, e_instr[14:12]});
      chk("IDReg_rs1",   {27'd0, IDReg_rs1},   {27'd0, e_instr[19:15]});
      chk("IDReg_rs2",   {27'd0, IDReg_rs2},   {27'd0, e_instr[24:20]});
      chk("IDReg_Func7", {25'd0, IDReg_Func7}, {25'd0, e_instr[31:25]});
      chk("if_diffen",   {31'd0, if_diffen},   {31'd0, e_diffen});
   endtask

   // Advance the model across one rising edge with the current inputs.
   task automatic model_edge();
      bit issue;
      bit loaded;
      issue  = !m_busy && !BPUClearCtr && imem_ready;
      loaded = 1'b0;
      if (m_busy && imem_rvalid) begin
         m_busy = 1'b0;
         if (!m_stale && !BPUClearCtr) begin
            e_pc     = m_req_pc;
            e_instr  = imem_rdata;
            e_diffen = 1'b1;
            loaded   = 1'b1;
            m_pc     = m_req_pc + 32'd4;
         end
      end
      if (!loaded) begin
         e_pc     = 32'h0;
         e_instr  = 32'h0;
         e_diffen = 1'b0;
      end
      if (BPUClearCtr) begin
         m_pc = {BPUTarget[31:2], 2'b00};
         if (m_busy) m_stale = 1'b1;
      end else if (issue) begin
         m_busy   = 1'b1;
         m_stale  = 1'b0;
         m_req_pc = m_pc;
      end
   endtask

   // One cycle: entered and left at a falling edge.
   task automatic cyc(input bit clr, input logic [31:0] tgt, input bit rdy,
                      input bit rv, input logic [31:0] rd);
      BPUClearCtr = clr;
      BPUTarget   = tgt;
      imem_ready  = rdy;
      imem_rvalid = rv;
      imem_rdata  = rd;
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Reset pulse starting at a falling edge, checked while asserted.
   task automatic do_reset();
      rst = 1'b1;
      BPUClearCtr = 1'b0; BPUTarget = 32'h0; imem_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      #1;
      model_reset();
      compare_all();
      chk("rst_req",    {31'd0, imem_req}, 32'd1);
      chk("rst_addr",   imem_addr, 32'h8000_0000);
      chk("rst_diffen", {31'd0, if_diffen}, 32'd0);
      chk("rst_idpc",   IDReg_PC, 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; BPUClearCtr = 1'b0; BPUTarget = 32'h0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Zero-wait memory, two instructions.
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
      chk("lit_pc0",     IDReg_PC, 32'h8000_0000);
      chk("lit_diffen0", {31'd0, if_diffen}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lit_bubble",  {31'd0, if_diffen}, 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093);
      chk("lit_pc1",     IDReg_PC, 32'h8000_0004);
      chk("lit_diffen1", {31'd0, if_diffen}, 32'd1);
      chk("lit_op",      {25'd0, IDReg_op},    32'h13);
      chk("lit_rd",      {27'd0, IDReg_Regrd}, 32'd1);
      chk("lit_rs1",     {27'd0, IDReg_rs1},   32'd0);
      chk("lit_f3",      {29'd0, IDReg_Func3}, 32'd0);
      chk("lit_f7",      {25'd0, IDReg_Func7}, 32'd0);

      // Memory not ready for three cycles.
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("lit_stall_addr", imem_addr, 32'h8000_0008);
      chk("lit_stall_req",  {31'd0, imem_req}, 32'd1);

      // Redirect while waiting; stale response arrives two cycles later.
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      chk("lit_drop_diffen", {31'd0, if_diffen}, 32'd0);
      chk("lit_drop_addr",   imem_addr, 32'h8000_0100);

      // Redirect in the same cycle as the response.
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 32'h8000_0200, 1'b0, 1'b1, 32'h1234_5678);
      chk("lit_same_diffen", {31'd0, if_diffen}, 32'd0);
      chk("lit_same_addr",   imem_addr, 32'h8000_0200);

      // Redirect in REQ: request is suppressed that cycle.
      BPUClearCtr = 1'b1;
      #1;
      chk("lit_req_clr", {31'd0, imem_req}, 32'd0);
      cyc(1'b1, 32'h8000_0300, 1'b1, 1'b0, 32'h0);
      chk("lit_req_tgt", imem_addr, 32'h8000_0300);

      // Reset while waiting, then a late response with the memory idle.
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      do_reset();
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
      chk("lit_late_diffen", {31'd0, if_diffen}, 32'd0);
      chk("lit_late_addr",   imem_addr, 32'h8000_0000);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0113);
      chk("lit_restart_pc", IDReg_PC, 32'h8000_0000);

      // PC wrap at the top of the address space.
      cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
      chk("lit_wrap_pc",   IDReg_PC, 32'hFFFF_FFFC);
      chk("lit_wrap_addr", imem_addr, 32'h0000_0000);

      // Misaligned redirect target.
      cyc(1'b1, 32'h8000_0102, 1'b0, 1'b0, 32'h0);
      chk("lit_align", imem_addr, 32'h8000_0100);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFE20_8A23);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage: holds the PC, issues one-outstanding requests to instruction memory, and writes the IF/ID pipeline register. The IDU consumes this register every cycle without stalling. Each fetched instruction is pre-decoded into opcode, register and function fields. On a branch-prediction redirect (`BPUClearCtr`) the stage discards in-flight work and restarts at the redirect target. Empty cycles are presented as all-zero bubbles with `if_diffen`=0.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC after reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `BPUClearCtr` in 1: redirect/flush, the same signal that flushes IDU.
- `BPUTarget` in 32: redirect PC, sampled when `BPUClearCtr`=1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address (current PC).
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid, one cycle wide.
- `imem_rdata` in 32: fetched instruction word.
- `IDReg_PC` out 32: PC of the registered instruction.
- `IDReg_Instr` out 32: registered instruction word.
- `IDReg_op` out 7: instr[6:0].
- `IDReg_Regrd` out 5: instr[11:7].
- `IDReg_Func3` out 3: instr[14:12].
- `IDReg_rs1` out 5: instr[19:15].
- `IDReg_rs2` out 5: instr[24:20].
- `IDReg_Func7` out 7: instr[31:25].
- `if_diffen` out 1: the IF/ID register holds a real instruction (used for difftest).

## Operation
- State register: `pc` (32 bits) plus FSM {REQ, WAIT, DROP}. Reset values: `pc`=`RESET_PC`, state=REQ.
- `imem_req` = (state==REQ) && !`BPUClearCtr`. This is combinational, so a request never handshakes in a redirect cycle.
- `imem_addr` = `pc` at all times.
- A request is accepted when `imem_req` && `imem_ready`. At most one request is outstanding.
- REQ state:
  - `BPUClearCtr`=1: `pc`<=`BPUTarget`; stay in REQ.
  - Otherwise, `imem_ready`=1: go to WAIT.
  - Otherwise: stay in REQ with the request held.
- WAIT state:
  - `imem_rvalid`=1 and `BPUClearCtr`=0: load the IF/ID register from `imem_rdata` with `IDReg_PC`=`pc`; `pc`<=`pc`+4; go to REQ.
  - `imem_rvalid`=1 and `BPUClearCtr`=1: discard the response; `pc`<=`BPUTarget`; go to REQ.
  - `imem_rvalid`=0 and `BPUClearCtr`=1: `pc`<=`BPUTarget`; go to DROP.
  - Neither: stay in WAIT.
- DROP state:
  - Waits for the stale response.
  - `imem_rvalid`=1: discard the response; go to REQ.
  - `BPUClearCtr`=1 in DROP: `pc`<=`BPUTarget`; stay in DROP until `imem_rvalid`.
- IF/ID register:
  - Loaded only on the WAIT-accept edge; that edge sets `if_diffen`<=1 and sets the predecode fields from `imem_rdata`.
  - On every other edge, including any edge with `BPUClearCtr`=1, every `IDReg_*` output is set to 0 and `if_diffen`<=0 (bubble).
- PC arithmetic: `pc`+4 is modulo 2^32 and wraps silently from 32'hFFFF_FFFC to 0. `BPUTarget`[1:0] is stored as 2'b00.
- `rst` asserted mid-transaction: state, `pc` and all outputs return to reset values immediately. A response arriving after reset deasserts while in REQ is ignored.
- `imem_rvalid` in REQ is ignored: it is a protocol error from the memory side and must not load the register.

## Timing
- Reset values: all `IDReg_*`=0, `if_diffen`=0, `imem_req`=1 (state REQ, `BPUClearCtr`=0), `imem_addr`=`RESET_PC`.
- Request accepted at edge N (state becomes WAIT). The earliest `imem_rvalid` is in the cycle after N. The instruction appears on `IDReg_*` after the edge on which `imem_rvalid` is sampled.
- Best-case throughput is one instruction every 2 cycles (REQ, WAIT alternating). A bubble is output in each REQ cycle.
- Redirect latency: `BPUClearCtr` at edge M puts `imem_addr`=`BPUTarget` from the cycle after M.
  - From REQ or WAIT-with-rvalid, the first request to the target goes out the cycle after M.
  - From DROP, it goes out the cycle after the stale response.
- The IF/ID outputs are pure registers; there is no combinational path from `imem_rdata` to `IDReg_*`.

## Test plan
- Reset, zero-wait memory (ready=1, rvalid the cycle after acceptance), words 0x00000013 and 0x00500093 -> `IDReg_PC` 0x80000000 then 0x80000004, `if_diffen` pulses 1,0,1, and for 0x00500093: op=0x13, rd=1, rs1=0, Func3=0, Func7=0.
- `imem_ready` held low 3 cycles in REQ -> `imem_addr` stable, `imem_req`=1, bubbles output, no PC change.
- `BPUClearCtr` with `BPUTarget`=0x80000100 in WAIT, rvalid 2 cycles later -> stale word dropped, `if_diffen` stays 0, next request address 0x80000100.
- `BPUClearCtr` in the same cycle as `imem_rvalid` -> no load, bubble, next address = target. `BPUClearCtr` in REQ -> `imem_req`=0 that cycle.
- `rst` pulsed while in WAIT, followed by a late rvalid -> outputs are 0, fetch restarts at `RESET_PC`, and the late response is ignored.
- PC at 0xFFFFFFFC fetched -> next `imem_addr`=0x00000000. `BPUTarget`=0x80000102 -> `imem_addr`=0x80000100.
